ifetch_stage: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the program counter and drives the word-indexed instruction memory address. It captures the returned instruction, together with its PC and PC+step, into the IF/ID pipeline register. It honours stall and flush from the hazard unit and redirects from EX (taken branch, jal, jalr).

---
 rtl/rv_pkg.sv | 18 +
 rtl/ifetch_stage_ifid_reg.sv | 26 ++
 rtl/ifetch_stage.sv | 73 +++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: fetch constants and the IF/ID payload.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'h0000_0001;  // word-indexed memory

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INST, pc: '0, pc_plus: '0, valid: 1'b0};

endpackage

// File: rtl/ifetch_stage_ifid_reg.sv
// Generic pipeline register: async active-low reset, hold on stall,
// load a bubble on flush (flush beats stall).
module ifid_reg #(
  parameter int unsigned      WIDTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Pipeline register update: reset/flush to bubble, otherwise capture unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE;
    end else if (flush) begin
      q <= BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection and the
// IF/ID pipeline register.
module ifetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = rv_pkg::RESET_PC[ADDR_WIDTH-1:0],
  parameter logic [ADDR_WIDTH-1:0] PC_STEP    = rv_pkg::PC_STEP[ADDR_WIDTH-1:0],
  parameter logic [INST_WIDTH-1:0] NOP_INST   = rv_pkg::NOP_INST[INST_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush_d,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_instr,
  output logic [ADDR_WIDTH-1:0] pc_f,
  output logic [INST_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus,
  output logic                  id_valid
);

  localparam int unsigned IFID_W = INST_WIDTH + 2 * ADDR_WIDTH + 1;
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INST, {ADDR_WIDTH{1'b0}}, {ADDR_WIDTH{1'b0}}, 1'b0};

  logic [ADDR_WIDTH-1:0] pc_plus;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [IFID_W-1:0]     ifid_d;
  logic [IFID_W-1:0]     ifid_q;

  assign pc_plus   = pc_f + PC_STEP;  // wraps modulo 2^ADDR_WIDTH
  assign imem_addr = pc_f;

  // Next-PC select: a redirect beats stall since the stalled fetch is wrong-path.
  always_comb begin
    pc_next = pc_plus;
    if (redirect_valid) begin
      pc_next = redirect_target;
    end else if (stall) begin
      pc_next = pc_f;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  assign ifid_d = {imem_instr, pc_f, pc_plus, 1'b1};

  ifid_reg #(
    .WIDTH  (IFID_W),
    .BUBBLE (IFID_BUBBLE)
  ) u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (redirect_valid | flush_d),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign {id_instr, id_pc, id_pc_plus, id_valid} = ifid_q;

endmodule
